run_split: RTL and testbench

Distribution stage feeding the two-way merge stage. Reads rows of COLUMN bytes from one source FIFO and copies them into two destination FIFOs (A and B), alternating destination every `run_len` rows. This turns an unsorted or partially merged stream into two run-interleaved streams that the merge stage consumes pairwise. The block is sequential:

- one row transferred every two cycles;
- full/empty back-pressure;
- a completion pulse.

---
 rtl/run_split.sv | 87 ++++++++
 tb/tb_run_split.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/run_split.sv
// run_split: distributes source rows into FIFOs A and B, alternating every run_len rows
// Ports:
//   clk, rst (async, active-low)
//   start, total_rows, run_len        : pass control, latched on start in IDLE
//   in_data, in_empty, rd_fifo        : FWFT source FIFO head, empty flag, pop strobe
//   full, wr_fifo, out_data           : destination full flags, push strobes, row ([0]=A, [1]=B)
//   busy, done, count_a, count_b      : status and per-destination row counts
module run_split #(
    parameter int COLUMN = 3,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       total_rows,
    input  logic [7:0]             run_len,
    input  logic [COLUMN-1:0][7:0] in_data,
    input  logic                   in_empty,
    input  logic [1:0]             full,
    output logic                   rd_fifo,
    output logic [1:0]             wr_fifo,
    output logic [COLUMN-1:0][7:0] out_data,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       count_a,
    output logic [CNT_W-1:0]       count_b
);
    typedef enum logic [1:0] {IDLE, FETCH, COMMIT, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] tot;
    logic [CNT_W-1:0] row_cnt;
    logic [7:0]       rl;
    logic [7:0]       run_cnt;
    logic             sel;
    assign busy = state != IDLE;
    assign done = state == DONE;
    // FIFO flags are only looked at in FETCH; COMMIT is a fixed strobe cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tot      <= '0;
            row_cnt  <= '0;
            rl       <= 8'd1;
            run_cnt  <= '0;
            sel      <= 1'b0;
            rd_fifo  <= 1'b0;
            wr_fifo  <= 2'b00;
            out_data <= '0;
            count_a  <= '0;
            count_b  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    tot     <= total_rows;
                    rl      <= (run_len == 8'd0) ? 8'd1 : run_len;
                    row_cnt <= '0;
                    run_cnt <= '0;
                    count_a <= '0;
                    count_b <= '0;
                    sel     <= 1'b0;
                    state   <= (total_rows != '0) ? FETCH : DONE;
                end
                FETCH: if (!in_empty && !full[sel]) begin
                    out_data <= in_data;
                    rd_fifo  <= 1'b1;
                    wr_fifo  <= sel ? 2'b10 : 2'b01;
                    state    <= COMMIT;
                end
                COMMIT: begin
                    rd_fifo <= 1'b0;
                    wr_fifo <= 2'b00;
                    if (sel) count_b <= count_b + 1'b1;
                    else     count_a <= count_a + 1'b1;
                    row_cnt <= row_cnt + 1'b1;
                    if (run_cnt == rl - 8'd1) begin
                        run_cnt <= 8'd0;
                        sel     <= ~sel;
                    end else begin
                        run_cnt <= run_cnt + 8'd1;
                    end
                    state <= (row_cnt == tot - 1'b1) ? DONE : FETCH;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_run_split.sv
// tb_run_split: scoreboard bench for run_split with source/destination FIFO models
module tb_run_split;
    localparam int COLUMN = 3;
    localparam int CNT_W  = 16;
    typedef logic [COLUMN-1:0][7:0] row_t;
    logic             clk = 0;
    logic             rst = 0;
    logic             start = 0;
    logic [CNT_W-1:0] total_rows = '0;
    logic [7:0]       run_len = '0;
    row_t             in_data = '0;
    logic             in_empty = 1;
    logic [1:0]       full = 2'b00;
    logic             rd_fifo;
    logic [1:0]       wr_fifo;
    row_t             out_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;
    run_split #(.COLUMN(COLUMN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .total_rows(total_rows), .run_len(run_len),
        .in_data(in_data), .in_empty(in_empty), .full(full), .rd_fifo(rd_fifo),
        .wr_fifo(wr_fifo), .out_data(out_data), .busy(busy), .done(done),
        .count_a(count_a), .count_b(count_b)
    );
    always #5 clk = ~clk;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         nr = 0;
    int         na = 0;
    int         nb = 0;
    row_t       src[$];
    row_t       exp_a[$];
    row_t       exp_b[$];
    logic       rnd_en = 0;
    logic       e_q = 1;
    logic [1:0] f_q = 2'b00;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic row_t mk(input int i);
        row_t r;
        for (int j = 0; j < COLUMN; j++) r[j] = i[7:0];
        return r;
    endfunction
    always @(posedge clk) begin
        e_q <= in_empty;
        f_q <= full;
    end
    // FIFO models: pop/capture on strobes seen mid-cycle, then refresh the source head
    always @(negedge clk) begin
        if (rd_fifo || wr_fifo != 2'b00)
            chk("strobe_pair", rd_fifo && (wr_fifo == 2'b01 || wr_fifo == 2'b10), 1);
        if (rd_fifo) begin
            chk("rd_while_empty", e_q, 0);
            nr++;
            if (src.size() != 0) void'(src.pop_front());
        end
        if (wr_fifo[0]) begin
            chk("wr_a_while_full", f_q[0], 0);
            na++;
            if (exp_a.size() == 0) chk("a_extra", 1, 0);
            else chk("a_row", out_data, exp_a.pop_front());
        end
        if (wr_fifo[1]) begin
            chk("wr_b_while_full", f_q[1], 0);
            nb++;
            if (exp_b.size() == 0) chk("b_extra", 1, 0);
            else chk("b_row", out_data, exp_b.pop_front());
        end
        in_empty = (src.size() == 0) || (rnd_en && $urandom_range(0, 1) == 1);
        in_data  = (src.size() != 0) ? src[0] : '0;
    end
    task automatic load(input int tot, input int rl, output int ea, output int eb);
        int sel = 0;
        int rc = 0;
        int rlx = (rl == 0) ? 1 : rl;
        ea = 0;
        eb = 0;
        src.delete();
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < tot; i++) begin
            src.push_back(mk(i));
            if (sel == 0) begin exp_a.push_back(mk(i)); ea++; end
            else begin exp_b.push_back(mk(i)); eb++; end
            rc++;
            if (rc == rlx) begin rc = 0; sel = 1 - sel; end
        end
        nr = 0;
        na = 0;
        nb = 0;
        repeat (2) @(negedge clk);
        total_rows = tot[CNT_W-1:0];
        run_len    = rl[7:0];
        start      = 1;
        @(posedge clk);
        #1 start = 0;
    endtask
    task automatic run_pass(input int tot, input int rl, input int lat_exp);
        int ea;
        int eb;
        int k = 0;
        load(tot, rl, ea, eb);
        while (!done && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_seen", done, 1);
        if (lat_exp >= 0) chk("done_latency", k, lat_exp);
        chk("count_a", count_a, ea);
        chk("count_b", count_b, eb);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("rd_pulses", nr, tot);
        chk("a_missing", exp_a.size(), 0);
        chk("b_missing", exp_b.size(), 0);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_rd"}, rd_fifo, 0);
        chk({tag, "_wr"}, wr_fifo, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cnt_a"}, count_a, 0);
        chk({tag, "_cnt_b"}, count_b, 0);
    endtask
    initial begin
        int ea;
        int eb;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1;
        @(negedge clk);
        chk_zero("post_reset");
        run_pass(6, 2, 12);
        run_pass(4, 0, 8);
        na = 0;
        fork
            run_pass(6, 3, -1);
            begin
                for (int k = 0; k < 200 && na < 3; k++) @(posedge clk);
                #1 full[1] = 1;
                repeat (10) begin
                    @(negedge clk);
                    chk("hold_quiet", {rd_fifo, wr_fifo}, 0);
                end
                full[1] = 0;
            end
        join
        rnd_en = 1;
        run_pass(20, 4, -1);
        rnd_en = 0;
        run_pass(0, 5, 0);
        load(6, 2, ea, eb);
        for (int k = 0; k < 200 && nr < 3; k++) @(posedge clk);
        for (int k = 0; k < 20 && !rd_fifo; k++) begin
            @(posedge clk);
            #1;
        end
        chk("row3_commit", rd_fifo, 1);
        #1 rst = 0;
        #1 chk_zero("async_reset");
        src.delete();
        exp_a.delete();
        exp_b.delete();
        @(negedge clk);
        rst = 1;
        run_pass(6, 2, 12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
